// File: rtl/stack_arbiter.sv
// Two-requester arbiter in front of an external stack, serialising push/pop transactions.
// Latency from the sampling edge: push done +2 cycles, pop done +3 cycles, error done +2 cycles.
// No backpressure: a requester holds req/op/wdata until gnt; a losing request stays pending.
//
// Ports: clk, rst (async active-low); per requester rN_req/op/wdata in, rN_gnt/done/rdata/err out;
// stack side stk_enable/push/pop/wdata out, stk_rdata/stk_sp in; status count/full/empty/busy.
// Optional feature: define STACK_RR_ARB_EN for round-robin arbitration (default fixed priority r0 > r1).
`timescale 1ns/1ps
module stack_arbiter #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int PTR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_op,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_op,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic              stk_enable,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_wdata,
    input  logic [DATA_W-1:0] stk_rdata,
    input  logic [PTR_W-1:0]  stk_sp,
    output logic [8:0]        count,
    output logic              full,
    output logic              empty,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    localparam logic [8:0] DEPTH_C = 9'(DEPTH);

    state_t            state_q, state_d;
    logic              idx_q;       // latched winner: 0 = r0, 1 = r1
    logic              op_q;        // latched op: 0 = push, 1 = pop
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [8:0]        count_q;
    logic              any_req;
    logic              win;
    logic              legal;

    // The stack pointer is informational only; occupancy is tracked locally.
    logic unused_sp;
    assign unused_sp = ^stk_sp;

    assign any_req = r0_req | r1_req;

`ifdef STACK_RR_ARB_EN
    logic last_q;  // requester granted most recently
    // On a tie the requester not granted last wins; otherwise the lone requester wins.
    assign win = r1_req & (~r0_req | ~last_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;  // pretend r1 went last so r0 wins the first tie
        end else if (state_q == IDLE && any_req) begin
            last_q <= win;
        end
    end
`else
    assign win = ~r0_req;
`endif

    // Legality is judged against the count at issue time, after any earlier transaction retired.
    assign legal = op_q ? (count_q != 9'd0) : (count_q != DEPTH_C);

    assign count = count_q;
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == 9'd0);
    assign busy  = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stk_enable = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_wdata  = '0;
        r0_gnt     = 1'b0;
        r1_gnt     = 1'b0;
        r0_done    = 1'b0;
        r1_done    = 1'b0;
        r0_err     = 1'b0;
        r1_err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                r0_gnt = ~idx_q;
                r1_gnt = idx_q;
                if (legal) begin
                    stk_enable = 1'b1;
                    stk_push   = ~op_q;
                    stk_pop    = op_q;
                    if (!op_q) begin
                        stk_wdata = wdata_q;
                    end
                    state_d = op_q ? CAPT : RESP;
                end else begin
                    state_d = RESP;
                end
            end
            CAPT: begin
                state_d = RESP;
            end
            RESP: begin
                r0_done = ~idx_q;
                r1_done = idx_q;
                r0_err  = ~idx_q & err_q;
                r1_err  = idx_q & err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q    <= 1'b0;
            op_q     <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            count_q  <= 9'd0;
            r0_rdata <= '0;
            r1_rdata <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        idx_q   <= win;
                        op_q    <= win ? r1_op : r0_op;
                        wdata_q <= win ? r1_wdata : r0_wdata;
                        err_q   <= 1'b0;
                    end
                end
                ISSUE: begin
                    err_q <= ~legal;
                    if (legal) begin
                        count_q <= op_q ? (count_q - 9'd1) : (count_q + 9'd1);
                    end
                end
                CAPT: begin
                    // Stack presents the popped word in the cycle after the pop strobe.
                    if (idx_q) begin
                        r1_rdata <= stk_rdata;
                    end else begin
                        r0_rdata <= stk_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
`timescale 1ns/1ps
module tb_stack_arbiter;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              r0_req, r0_op, r1_req, r1_op;
    logic [DATA_W-1:0] r0_wdata, r1_wdata;
    logic              r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
    logic [DATA_W-1:0] r0_rdata, r1_rdata;
    logic              stk_enable, stk_push, stk_pop;
    logic [DATA_W-1:0] stk_wdata, stk_rdata;
    logic [7:0]        stk_sp;
    logic [8:0]        count;
    logic              full, empty, busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: stack contents and the last popped word per requester.
    logic [DATA_W-1:0] model[$];
    logic [DATA_W-1:0] last_rd[2];

    always #5 clk = ~clk;

    stack_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_op(r0_op), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt),
        .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_op(r1_op), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt),
        .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .stk_enable(stk_enable), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .stk_sp(stk_sp),
        .count(count), .full(full), .empty(empty), .busy(busy)
    );

    // External stack memory: popped word appears on stk_rdata the cycle after the pop strobe.
    logic [DATA_W-1:0] env_mem [DEPTH];
    int                env_sp;
    logic [DATA_W-1:0] pop_dat;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            env_sp  <= 0;
            pop_dat <= '0;
        end else if (stk_push && env_sp < DEPTH) begin
            env_mem[env_sp] <= stk_wdata;
            env_sp          <= env_sp + 1;
        end else if (stk_pop && env_sp > 0) begin
            pop_dat <= env_mem[env_sp-1];
            env_sp  <= env_sp - 1;
        end
    end
    assign stk_rdata = pop_dat;
    assign stk_sp    = 8'(env_sp);

    task automatic do_reset();
        r0_req = 1'b0;
        r1_req = 1'b0;
        rst    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    // One complete transaction from a single requester, checked against the model.
    task automatic do_txn(input int who, input bit op, input logic [DATA_W-1:0] wd);
        int cyc, n_push, n_pop, exp_lat, exp_cnt;
        bit done_seen, exp_legal;
        logic [DATA_W-1:0] exp_rd;
        logic own_gnt, oth_gnt, own_done, oth_done, own_err;
        logic [DATA_W-1:0] own_rd, oth_rd;
        exp_legal = op ? (model.size() > 0) : (model.size() < DEPTH);
        exp_rd    = (op && exp_legal) ? model[$] : '0;
        exp_cnt   = model.size() + (exp_legal ? (op ? -1 : 1) : 0);
        exp_lat   = (exp_legal && op) ? 3 : 2;
        if (who == 0) begin r0_req = 1'b1; r0_op = op; r0_wdata = wd; end
        else          begin r1_req = 1'b1; r1_op = op; r1_wdata = wd; end
        cyc = 0; n_push = 0; n_pop = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
            own_gnt  = (who == 0) ? r0_gnt  : r1_gnt;
            oth_gnt  = (who == 0) ? r1_gnt  : r0_gnt;
            own_done = (who == 0) ? r0_done : r1_done;
            oth_done = (who == 0) ? r1_done : r0_done;
            own_err  = (who == 0) ? r0_err  : r1_err;
            own_rd   = (who == 0) ? r0_rdata : r1_rdata;
            oth_rd   = (who == 0) ? r1_rdata : r0_rdata;
            if (cyc == 1) begin
                checks++;
                if (own_gnt !== 1'b1) begin failures++; $display("FAIL gnt_cycle1 r%0d got=%b exp=1", who, own_gnt); end
                checks++;
                if (oth_gnt !== 1'b0) begin failures++; $display("FAIL other_gnt r%0d got=%b exp=0", who, oth_gnt); end
                r0_req = 1'b0;
                r1_req = 1'b0;
            end
            checks++;
            if ((stk_push & stk_pop) !== 1'b0) begin failures++; $display("FAIL push_and_pop cyc=%0d got=1 exp=0", cyc); end
            if (stk_push === 1'b1) begin
                n_push++;
                checks++;
                if (stk_wdata !== wd) begin failures++; $display("FAIL stk_wdata got=%h exp=%h", stk_wdata, wd); end
            end
            if (stk_pop === 1'b1) n_pop++;
            if (own_done === 1'b1) begin
                done_seen = 1'b1;
                checks++;
                if (cyc != exp_lat) begin failures++; $display("FAIL done_latency op=%0d got=%0d exp=%0d", op, cyc, exp_lat); end
                checks++;
                if (own_err !== !exp_legal) begin failures++; $display("FAIL err got=%b exp=%b", own_err, !exp_legal); end
                checks++;
                if (oth_done !== 1'b0) begin failures++; $display("FAIL other_done got=%b exp=0", oth_done); end
                checks++;
                if (count !== 9'(exp_cnt)) begin failures++; $display("FAIL count got=%0d exp=%0d", count, exp_cnt); end
                checks++;
                if (empty !== (exp_cnt == 0)) begin failures++; $display("FAIL empty got=%b exp=%b", empty, exp_cnt == 0); end
                checks++;
                if (full !== (exp_cnt == DEPTH)) begin failures++; $display("FAIL full got=%b exp=%b", full, exp_cnt == DEPTH); end
                if (op && exp_legal) begin
                    checks++;
                    if (own_rd !== exp_rd) begin failures++; $display("FAIL rdata r%0d got=%h exp=%h", who, own_rd, exp_rd); end
                    checks++;
                    if (oth_rd !== last_rd[1-who]) begin failures++; $display("FAIL rdata_hold r%0d got=%h exp=%h", 1-who, oth_rd, last_rd[1-who]); end
                end
            end
        end
        checks++;
        if (!done_seen) begin failures++; $display("FAIL done_timeout r%0d got=none exp=done", who); end
        checks++;
        if (n_push != ((exp_legal && !op) ? 1 : 0)) begin failures++; $display("FAIL push_strobes got=%0d exp=%0d", n_push, (exp_legal && !op) ? 1 : 0); end
        checks++;
        if (n_pop != ((exp_legal && op) ? 1 : 0)) begin failures++; $display("FAIL pop_strobes got=%0d exp=%0d", n_pop, (exp_legal && op) ? 1 : 0); end
        if (exp_legal) begin
            if (op) begin void'(model.pop_back()); last_rd[who] = exp_rd; end
            else    model.push_back(wd);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_resp got=%b exp=0", busy); end
    endtask

    task automatic test_reset();
        r0_req = 1'b1; r0_op = 1'b0; r0_wdata = 32'hDEADBEEF;
        r1_req = 1'b1; r1_op = 1'b1; r1_wdata = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (count !== 9'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++;
        if ({r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err} !== 6'b0) begin
            failures++; $display("FAIL rst_handshake got=%b exp=0", {r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err});
        end
        checks++;
        if ({stk_enable, stk_push, stk_pop} !== 3'b0) begin failures++; $display("FAIL rst_strobes got=%b exp=0", {stk_enable, stk_push, stk_pop}); end
        checks++;
        if (r0_rdata !== '0 || r1_rdata !== '0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0", r0_rdata, r1_rdata); end
        do_reset();
    endtask

    task automatic test_push();
        do_txn(0, 1'b0, 32'h12345678);
    endtask

    task automatic test_pop();
        do_txn(1, 1'b1, '0);
    endtask

    task automatic test_underflow();
        do_txn(0, 1'b1, '0);
    endtask

    task automatic test_full();
        int n = 0;
        while (model.size() < DEPTH && n < 2 * DEPTH) begin
            do_txn(n % 2, 1'b0, $urandom);
            n++;
        end
        do_txn(0, 1'b0, 32'hA5A5A5A5);
        do_txn(1, 1'b1, '0);
    endtask

    task automatic test_arbitration();
        int grants[$];
        int cyc, exp_w;
        logic [DATA_W-1:0] d0, d1;
        do_reset();
        d0 = $urandom; d1 = $urandom;
        r0_req = 1'b1; r0_op = 1'b0; r0_wdata = d0;
        r1_req = 1'b1; r1_op = 1'b0; r1_wdata = d1;
        cyc = 0;
        while (grants.size() < 4 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (r0_gnt === 1'b1 || r1_gnt === 1'b1) begin
                checks++;
                if (r0_gnt === 1'b1 && r1_gnt === 1'b1) begin failures++; $display("FAIL dual_gnt got=11 exp=one-hot"); end
                grants.push_back(r1_gnt === 1'b1 ? 1 : 0);
                checks++;
                if (stk_push !== 1'b1 || stk_wdata !== (r1_gnt ? d1 : d0)) begin
                    failures++; $display("FAIL arb_push got=%b/%h exp=1/%h", stk_push, stk_wdata, r1_gnt ? d1 : d0);
                end
                model.push_back(r1_gnt ? d1 : d0);
            end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        checks++;
        if (grants.size() != 4) begin failures++; $display("FAIL arb_grant_count got=%0d exp=4", grants.size()); end
        foreach (grants[i]) begin
`ifdef STACK_RR_ARB_EN
            exp_w = i % 2;
`else
            exp_w = 0;
`endif
            checks++;
            if (grants[i] != exp_w) begin failures++; $display("FAIL arb_order idx=%0d got=r%0d exp=r%0d", i, grants[i], exp_w); end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (count !== 9'(model.size())) begin failures++; $display("FAIL arb_count got=%0d exp=%0d", count, model.size()); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL arb_busy got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            do_txn($urandom_range(0, 1), ($urandom_range(0, 9) < 5), $urandom);
        end
    endtask

    task automatic test_reset_mid();
        do_txn(0, 1'b0, $urandom);
        // Reset while a pop sits in CAPT.
        r1_req = 1'b1; r1_op = 1'b1;
        @(posedge clk); #1;
        checks++; if (r1_gnt !== 1'b1) begin failures++; $display("FAIL mid_gnt got=%b exp=1", r1_gnt); end
        checks++; if (stk_pop !== 1'b1) begin failures++; $display("FAIL mid_pop got=%b exp=1", stk_pop); end
        r1_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1 || r1_done !== 1'b0) begin failures++; $display("FAIL mid_capt got=%b%b exp=10", busy, r1_done); end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (count !== 9'd0 || empty !== 1'b1) begin failures++; $display("FAIL mid_count got=%0d/%b exp=0/1", count, empty); end
        checks++; if (r1_rdata !== '0) begin failures++; $display("FAIL mid_rdata got=%h exp=0", r1_rdata); end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ((r0_done | r1_done) !== 1'b0) begin failures++; $display("FAIL mid_done got=1 exp=0"); end
        end
        rst = 1'b1;
        model.delete(); last_rd[0] = '0; last_rd[1] = '0;
        // Reset while a push strobe is on the stack bus.
        r0_req = 1'b1; r0_op = 1'b0; r0_wdata = $urandom;
        @(posedge clk); #1;
        checks++; if (stk_push !== 1'b1) begin failures++; $display("FAIL issue_push got=%b exp=1", stk_push); end
        rst = 1'b0; r0_req = 1'b0;
        #1;
        checks++;
        if ({stk_enable, stk_push, r0_gnt} !== 3'b0) begin failures++; $display("FAIL strobe_abort got=%b exp=0", {stk_enable, stk_push, r0_gnt}); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model.delete();
        do_txn(0, 1'b0, 32'hCAFEF00D);
        do_txn(1, 1'b1, '0);
    endtask

    initial begin
        rst = 1'b0;
        r0_req = 1'b0; r0_op = 1'b0; r0_wdata = '0;
        r1_req = 1'b0; r1_op = 1'b0; r1_wdata = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        test_reset();
        test_push();
        test_pop();
        test_underflow();
        test_full();
        test_arbitration();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stack word width.
REQ-002 SHALL have parameter DEPTH, default 256, stack capacity in words; PTR_W = 8 addresses it.
REQ-003 SHALL have ports `clk` (in, 1, sole clock) and `rst` (in, 1, asynchronous active-low reset).
REQ-004 SHALL have, for requester x in {0,1}, the following ports:
- rx_req (in, 1): request.
- rx_op (in, 1): 0 = push, 1 = pop.
- rx_wdata (in, DATA_W): push data.
- rx_gnt (out, 1): grant pulse.
- rx_done (out, 1): completion pulse.
- rx_rdata (out, DATA_W): pop data.
- rx_err (out, 1): overflow/underflow flag.
REQ-005 SHALL have stack-side ports:
- stk_enable, stk_push, stk_pop (out, 1): strobes.
- stk_wdata (out, DATA_W).
- stk_rdata (in, DATA_W).
- stk_sp (in, 8): stack pointer, informational.
REQ-006 SHALL have status ports:
- count (out, 9): occupancy.
- full (out, 1).
- empty (out, 1).
- busy (out, 1): state != IDLE.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, CAPT, RESP.
REQ-008 In IDLE, SHALL at a clock edge with any rx_req high select one winner, latch its op/wdata/index, and go to ISSUE.
REQ-009 SHALL assert the winner's rx_gnt for exactly the ISSUE cycle.
REQ-010 In ISSUE, a legal push SHALL drive stk_enable=1, stk_push=1, stk_wdata=latched data for one cycle, increment count, and go to RESP.
REQ-011 In ISSUE, a legal pop SHALL drive stk_enable=1, stk_pop=1 for one cycle, decrement count, and go to CAPT.
REQ-012 In CAPT, SHALL register stk_rdata into the winner's rx_rdata and go to RESP.
REQ-013 SHALL treat a push with count==DEPTH, or a pop with count==0, as illegal:
- no stk_* strobe is issued;
- count is unchanged;
- the FSM goes directly to RESP with rx_err=1.
REQ-014 In RESP, SHALL pulse the winner's rx_done for one cycle, with rx_err valid in the same cycle, then return to IDLE.
REQ-015 SHALL hold rx_rdata until that requester's next pop completes.
REQ-016 Latency, measured from the sampling edge:
- push done: 2 cycles;
- pop done: 3 cycles;
- error done: 2 cycles.
REQ-017 SHALL keep all stk_* strobes at 0 outside ISSUE and never assert stk_push and stk_pop together.
REQ-018 SHALL sample only in IDLE, so a requester holds req/op/wdata until gnt, then drops req; req still high after RESP is a new request.
REQ-019 SHALL drive full = (count==DEPTH) and empty = (count==0) combinationally from count.
REQ-020 SHALL give the non-winner no gnt; its request stays pending and is served in the next IDLE sample.

Reset
REQ-021 `rst`=0 SHALL asynchronously force IDLE and set the following:
- count=0, empty=1, full=0, busy=0;
- all gnt/done/err/stk_* = 0;
- all rx_rdata = 0;
- arbitration pointer favouring r0.
REQ-022 Reset mid-transaction SHALL abort the transaction with no done pulse; any stk strobe is removed immediately.
REQ-023 After `rst` returns to 1, SHALL sample requests starting from the first rising edge.

Configuration
REQ-024 With STACK_RR_ARB_EN defined, SHALL arbitrate round-robin: on simultaneous requests, the requester not granted last wins, and the pointer updates on each grant.
REQ-025 Without STACK_RR_ARB_EN, SHALL use fixed priority, where r0 always wins over r1.

Verification
REQ-026 Reset, then r0 pushes 32'h12345678 -> r0_gnt in cycle 1, one stk_push strobe, r0_done at cycle 2, count=1, empty=0.
REQ-027 From count=1, r1 pops -> one stk_pop strobe, r1_rdata=32'h12345678 with r1_done at cycle 3, count=0, empty=1.
REQ-028 Pop with count=0 -> no stk strobe, r0_done with r0_err=1, count stays 0; push 256 times, then push once more -> full=1, r0_err=1, count=256.
REQ-029 r0 and r1 request together, held for four transactions:
- with STACK_RR_ARB_EN, grants alternate r0, r1, r0, r1;
- without it, r0 is granted every time while it holds req.
REQ-030 Pull `rst` low during CAPT of a pop -> FSM returns to IDLE, there is no done pulse, count=0, and the next push completes normally.
